microwave_ctrl: RTL



---
 rtl/mwc_pkg.sv | 25 ++
 rtl/mwc_fall_edge.sv | 19 +
 rtl/microwave_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mwc_pkg.sv
// Shared types and constants for the microwave sequencing controller.
package mwc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET,
    ST_COOK,
    ST_PAUSE,
    ST_DONE
  } mwc_state_e;

  localparam int NUM_DIGITS_DEF = 4;
  localparam int TICK_DIV_DEF   = 100;

  // Width of a counter that has to hold the values 0..value-1.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mwc_fall_edge.sv
// Registered falling-edge detector for active-low strobes; history resets to 0,
// so a line that is held low through reset release produces no event.
module mwc_fall_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic fall_o
);

  logic hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist_q <= 1'b0;
    else     hist_q <= sig_i;
  end

  assign fall_o = hist_q & ~sig_i;

endmodule

// File: rtl/microwave_ctrl.sv
// Microwave sequencing FSM: digit entry, cook/pause/done control, timer tick generation.
// Optional MWC_DONE_BEEP_EN adds a beep output that sounds for BEEP_CYCLES on DONE entry.
//   state | meaning
//   IDLE  | no digits entered, timer zeroed
//   SET   | digits being entered
//   COOK  | magnetron on, ticking the timer down
//   PAUSE | cooking suspended, tick phase held
//   DONE  | timer reached zero, waiting for acknowledge
module microwave_ctrl
  import mwc_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int CNT_W      = 3
`ifdef MWC_DONE_BEEP_EN
  , parameter int BEEP_CYCLES = 300
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             loadn,
  input  logic             startn,
  input  logic             stopn,
  input  logic             clearn,
  input  logic             door_closed,
  input  logic             timer_zero,
  output logic             mag_on,
  output logic             timer_load,
  output logic             timer_tick,
  output logic             timer_clear,
  output logic             done,
  output logic [CNT_W-1:0] digit_cnt
`ifdef MWC_DONE_BEEP_EN
  , output logic           beep
`endif
);

  localparam int TW = clog2(TICK_DIV);
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] DIG_MAX   = CNT_W'(NUM_DIGITS);

  logic key_ev, start_ev, stop_ev, clear_ev;

  mwc_fall_edge u_key   (.clk(clk), .rst(rst), .sig_i(loadn),  .fall_o(key_ev));
  mwc_fall_edge u_start (.clk(clk), .rst(rst), .sig_i(startn), .fall_o(start_ev));
  mwc_fall_edge u_stop  (.clk(clk), .rst(rst), .sig_i(stopn),  .fall_o(stop_ev));
  mwc_fall_edge u_clear (.clk(clk), .rst(rst), .sig_i(clearn), .fall_o(clear_ev));

  mwc_state_e       state_q, state_d;
  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [CNT_W-1:0] digit_cnt_q, digit_cnt_d;
  logic             mag_on_q, load_q, tick_q, clear_q, done_q;
  logic             load_d, tick_d, clear_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      digit_cnt_q <= '0;
      mag_on_q    <= 1'b0;
      load_q      <= 1'b0;
      tick_q      <= 1'b0;
      clear_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      digit_cnt_q <= digit_cnt_d;
      mag_on_q    <= (state_d == ST_COOK);
      load_q      <= load_d;
      tick_q      <= tick_d;
      clear_q     <= clear_d;
      done_q      <= (state_d == ST_DONE);
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    digit_cnt_d = digit_cnt_q;
    load_d      = 1'b0;
    tick_d      = 1'b0;
    clear_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_ev) begin
          clear_d = 1'b1;
        end else if (key_ev) begin
          load_d      = 1'b1;
          digit_cnt_d = CNT_W'(1);
          state_d     = ST_SET;
        end
      end
      ST_SET: begin
        if (clear_ev) begin
          clear_d     = 1'b1;
          digit_cnt_d = '0;
          state_d     = ST_IDLE;
        end else if (start_ev) begin
          if (door_closed && !timer_zero) begin
            state_d    = ST_COOK;
            tick_cnt_d = '0;
          end
        end else if (key_ev && (digit_cnt_q < DIG_MAX)) begin
          load_d      = 1'b1;
          digit_cnt_d = digit_cnt_q + CNT_W'(1);
        end
      end
      ST_COOK: begin
        if (clear_ev) begin
          clear_d     = 1'b1;
          digit_cnt_d = '0;
          state_d     = ST_IDLE;
        end else if (stop_ev || !door_closed) begin
          state_d = ST_PAUSE;
        end else if (timer_zero) begin
          state_d = ST_DONE;
        end else if (tick_cnt_q == TICK_LAST) begin
          tick_cnt_d = '0;
          tick_d     = 1'b1;
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
      ST_PAUSE: begin
        if (stop_ev || clear_ev) begin
          clear_d     = 1'b1;
          digit_cnt_d = '0;
          state_d     = ST_IDLE;
        end else if (start_ev && door_closed) begin
          state_d = ST_COOK;
        end
      end
      ST_DONE: begin
        if (start_ev || stop_ev || clear_ev || !door_closed) begin
          clear_d     = 1'b1;
          digit_cnt_d = '0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mag_on      = mag_on_q;
  assign timer_load  = load_q;
  assign timer_tick  = tick_q;
  assign timer_clear = clear_q;
  assign done        = done_q;
  assign digit_cnt   = digit_cnt_q;

`ifdef MWC_DONE_BEEP_EN
  localparam int BW = clog2(BEEP_CYCLES + 1);

  logic          beep_q;
  logic [BW-1:0] beep_cnt_q;

  // Down-counter loaded on DONE entry; the tone ends at terminal count or on exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beep_q     <= 1'b0;
      beep_cnt_q <= '0;
    end else if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      beep_q     <= 1'b1;
      beep_cnt_q <= BW'(BEEP_CYCLES - 1);
    end else if (state_d != ST_DONE) begin
      beep_q <= 1'b0;
    end else if (beep_cnt_q == '0) begin
      beep_q <= 1'b0;
    end else begin
      beep_cnt_q <= beep_cnt_q - BW'(1);
    end
  end

  assign beep = beep_q;
`endif

endmodule
